// File: rtl/apb_ral_slave.sv
// apb_ral_slave: APB (AMBA 3, no PSLVERR) register file, zero wait states.
//
// Register map (byte offsets, only mapped when paddr[31:5] == 0, paddr[1:0] ignored):
//   0x00 CTRL  [3:0] RW, upper bits read 0
//   0x04 REG1  32-bit RW
//   0x08 REG2  32-bit RW
//   0x0C REG3  32-bit RW
//   0x10 ID    RO, reads IdValue
//   other offsets read 0, writes dropped
//
// Ports:
//   pclk     in   APB clock, rising edge
//   presetn  in   asynchronous active-low reset
//   paddr    in   byte address
//   pwdata   in   write data
//   psel     in   slave select
//   penable  in   access phase indicator
//   pwrite   in   1 = write, 0 = read
//   prdata   out  registered read data, held until the next read capture
//   pready   out  registered, high exactly in the ACCESS cycle

module apb_ral_slave (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  output logic [31:0] prdata,
  output logic        pready
);

  localparam logic [31:0] IdValue = 32'hA5B0_0001;

  // state_q records the bus phase of the cycle that ended at the last edge.
  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } state_e;

  state_e      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] reg1_q;
  logic [31:0] reg2_q;
  logic [31:0] reg3_q;
  logic [31:0] prdata_q;
  logic        pready_q;

  logic        mapped;
  logic [2:0]  reg_idx;
  logic [31:0] rd_value;
  logic        setup_now;
  logic        write_commit;

  logic unused_addr;
  assign unused_addr = ^paddr[1:0];

  assign mapped       = (paddr[31:5] == 27'd0);
  assign reg_idx      = paddr[4:2];
  assign setup_now    = psel & ~penable;
  // pready_q is only high in a legitimate ACCESS cycle, so a psel+penable seen
  // straight out of IDLE never commits.
  assign write_commit = psel & penable & pwrite & pready_q;

  always_comb begin
    rd_value = 32'd0;
    if (mapped) begin
      case (reg_idx)
        3'd0:    rd_value = {28'd0, ctrl_q};
        3'd1:    rd_value = reg1_q;
        3'd2:    rd_value = reg2_q;
        3'd3:    rd_value = reg3_q;
        3'd4:    rd_value = IdValue;
        default: rd_value = 32'd0;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= StIdle;
      ctrl_q   <= 4'd0;
      reg1_q   <= 32'd0;
      reg2_q   <= 32'd0;
      reg3_q   <= 32'd0;
      prdata_q <= 32'd0;
      pready_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // psel with penable already high is a protocol violation: stay idle.
          state_q <= setup_now ? StSetup : StIdle;
        end
        StSetup: begin
          if (psel && penable) begin
            state_q <= StAccess;
          end else if (setup_now) begin
            state_q <= StSetup;
          end else begin
            state_q <= StIdle;
          end
        end
        StAccess: begin
          // Back-to-back transfer keeps psel high and drops penable.
          state_q <= setup_now ? StSetup : StIdle;
        end
        default: state_q <= StIdle;
      endcase

      pready_q <= setup_now;

      if (setup_now && !pwrite) begin
        prdata_q <= rd_value;
      end

      if (write_commit && mapped) begin
        case (reg_idx)
          3'd0:    ctrl_q <= pwdata[3:0];
          3'd1:    reg1_q <= pwdata;
          3'd2:    reg2_q <= pwdata;
          3'd3:    reg3_q <= pwdata;
          default: ;
        endcase
      end
    end
  end

  assign prdata = prdata_q;
  assign pready = pready_q;

endmodule

// File: tb/tb_apb_ral_slave.sv
// Directed bench for apb_ral_slave: hand-computed expected values for each access.

module tb_apb_ral_slave;

  localparam logic [31:0] IdVal = 32'hA5B0_0001;

  logic        pclk;
  logic        presetn;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] prdata;
  logic        pready;

  int checks;
  int errors;

  logic [31:0] rd;

  apb_ral_slave u_dut (
    .pclk    (pclk),
    .presetn (presetn),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .prdata  (prdata),
    .pready  (pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One transfer, entered #1 after a rising edge. SETUP then ACCESS; pready is
  // checked low in SETUP and high in ACCESS. rdata is prdata seen in ACCESS.
  // With last=0 psel stays high so the next call forms a back-to-back transfer.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic last,
                      output logic [31:0] rdata);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(negedge pclk);
    check_eq({tag, "_setup_rdy"}, {31'd0, pready}, 32'd0);
    @(posedge pclk);
    #1 penable = 1'b1;
    @(negedge pclk);
    check_eq({tag, "_access_rdy"}, {31'd0, pready}, 32'd1);
    rdata = prdata;
    @(posedge pclk);
    #1;
    if (last) begin
      psel    = 1'b0;
      penable = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge pclk);
    check_eq({tag, "_idle_rdy"}, {31'd0, pready}, 32'd0);
    @(posedge pclk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    presetn = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'd0;
    pwdata  = 32'd0;

    repeat (2) @(negedge pclk);
    check_eq("por_pready", {31'd0, pready}, 32'd0);
    check_eq("por_prdata", prdata, 32'd0);
    presetn = 1'b1;
    @(posedge pclk);
    #1;

    // Preload non-zero state so the reset is observable.
    xfer("pre_w1", 1'b1, 32'h04, 32'h1111_1111, 1'b1, rd);
    xfer("pre_w2", 1'b1, 32'h08, 32'h2222_2222, 1'b1, rd);
    xfer("pre_w3", 1'b1, 32'h0C, 32'h3333_3333, 1'b1, rd);
    xfer("pre_wc", 1'b1, 32'h00, 32'h0000_0009, 1'b1, rd);
    xfer("pre_r1", 1'b0, 32'h04, 32'd0, 1'b1, rd);
    check_eq("pre_r1_data", rd, 32'h1111_1111);

    // Reset asserted mid-ACCESS of a write to REG1.
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h04;
    pwdata  = 32'hFFFF_0000;
    @(posedge pclk);
    #1 penable = 1'b1;
    #2 presetn = 1'b0;
    #1;
    check_eq("rst_pready", {31'd0, pready}, 32'd0);
    check_eq("rst_prdata", prdata, 32'd0);
    @(posedge pclk);
    #1 psel = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    check_eq("rst_hold_pready", {31'd0, pready}, 32'd0);
    presetn = 1'b1;
    @(posedge pclk);
    #1;

    xfer("rst_r1", 1'b0, 32'h04, 32'd0, 1'b1, rd);
    check_eq("rst_r1_data", rd, 32'd0);
    xfer("rst_r2", 1'b0, 32'h08, 32'd0, 1'b1, rd);
    check_eq("rst_r2_data", rd, 32'd0);
    xfer("rst_r3", 1'b0, 32'h0C, 32'd0, 1'b1, rd);
    check_eq("rst_r3_data", rd, 32'd0);
    xfer("rst_rc", 1'b0, 32'h00, 32'd0, 1'b1, rd);
    check_eq("rst_rc_data", rd, 32'd0);
    xfer("rst_rid", 1'b0, 32'h10, 32'd0, 1'b1, rd);
    check_eq("rst_rid_data", rd, IdVal);

    // REG1 write/read.
    xfer("w_reg1", 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b1, rd);
    idle_check("after_w_reg1");
    xfer("r_reg1", 1'b0, 32'h04, 32'd0, 1'b1, rd);
    check_eq("r_reg1_data", rd, 32'hDEAD_BEEF);

    // CTRL: only bits [3:0] stick; a write leaves prdata alone.
    xfer("w_ctrl", 1'b1, 32'h00, 32'hFFFF_FFFF, 1'b1, rd);
    check_eq("w_ctrl_prdata_held", rd, 32'hDEAD_BEEF);
    xfer("r_ctrl", 1'b0, 32'h00, 32'd0, 1'b1, rd);
    check_eq("r_ctrl_data", rd, 32'h0000_000F);

    // ID is read-only.
    xfer("w_id", 1'b1, 32'h10, 32'h1234_5678, 1'b1, rd);
    xfer("r_id", 1'b0, 32'h10, 32'd0, 1'b1, rd);
    check_eq("r_id_data", rd, IdVal);

    // REG2/REG3 and an unmapped offset.
    xfer("w_reg2", 1'b1, 32'h08, 32'h5555_AAAA, 1'b1, rd);
    xfer("w_reg3", 1'b1, 32'h0C, 32'h5555_AAAA, 1'b1, rd);
    xfer("w_unmap", 1'b1, 32'h100, 32'h5555_AAAA, 1'b1, rd);
    xfer("r_reg2", 1'b0, 32'h08, 32'd0, 1'b1, rd);
    check_eq("r_reg2_data", rd, 32'h5555_AAAA);
    xfer("r_reg3", 1'b0, 32'h0C, 32'd0, 1'b1, rd);
    check_eq("r_reg3_data", rd, 32'h5555_AAAA);
    xfer("r_unmap", 1'b0, 32'h100, 32'd0, 1'b1, rd);
    check_eq("r_unmap_data", rd, 32'd0);
    xfer("r_0a", 1'b0, 32'h0A, 32'd0, 1'b1, rd);
    check_eq("r_0a_data", rd, 32'h5555_AAAA);
    // 0x14 lies in the mapped window but has no register.
    xfer("r_14", 1'b0, 32'h14, 32'd0, 1'b1, rd);
    check_eq("r_14_data", rd, 32'd0);

    // psel+penable straight out of IDLE must be ignored.
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 32'h04;
    pwdata  = 32'h0000_0BAD;
    @(negedge pclk);
    check_eq("viol_rdy", {31'd0, pready}, 32'd0);
    @(posedge pclk);
    #1 psel = 1'b0;
    penable = 1'b0;
    idle_check("after_viol");
    xfer("r_viol", 1'b0, 32'h04, 32'd0, 1'b1, rd);
    check_eq("r_viol_data", rd, 32'hDEAD_BEEF);

    // Back-to-back write then read of REG3, psel held high throughout.
    xfer("b2b_w", 1'b1, 32'h0C, 32'hCAFE_0001, 1'b0, rd);
    check_eq("b2b_psel_held", {31'd0, psel}, 32'd1);
    xfer("b2b_r", 1'b0, 32'h0C, 32'd0, 1'b1, rd);
    check_eq("b2b_r_data", rd, 32'hCAFE_0001);
    idle_check("after_b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
